seg_dynamic_scan: RTL and testbench

//  Time-multiplexed 6-digit seven-segment scan driver, directly downstream of bcd_8421.

---
 rtl/seg_pkg.sv | 29 ++
 rtl/seg_dynamic_scan.sv | 132 +++++++++++++
 tb/tb_seg_dynamic_scan.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared constants and the BCD-to-segment decode for the seg_dynamic_scan slice.
// Segment codes are active-low, bit order {dp,g,f,e,d,c,b,a}.
package seg_pkg;

    localparam int NUM_DIGITS = 6;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_MINUS = 8'hBF;

    // Non-decimal codes 10..15 decode to blank.
    function automatic logic [7:0] bcd_to_seg(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'd0:    s = 8'hC0;
            4'd1:    s = 8'hF9;
            4'd2:    s = 8'hA4;
            4'd3:    s = 8'hB0;
            4'd4:    s = 8'h99;
            4'd5:    s = 8'h92;
            4'd6:    s = 8'h82;
            4'd7:    s = 8'hF8;
            4'd8:    s = 8'h80;
            4'd9:    s = 8'h90;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg_dynamic_scan.sv
// Six-digit time-multiplexed seven-segment scan driver with leading-zero
// blanking, sign placement and per-digit decimal points.
// Ports:
//   sys_clk, sys_rst          clock, async active-high reset
//   unit..h_hun [3:0]         BCD digits 0 (right) .. 5 (left)
//   point [5:0]               decimal point enable per digit
//   sign                      show '-' left of the most significant digit
//   seg_en                    0 blanks the display, scanning continues
//   sel [5:0]                 one-hot digit select, active-high
//   seg [7:0]                 segments, active-low {dp,g,f,e,d,c,b,a}
//   frame_done                one-cycle pulse after digit 5's dwell
module seg_dynamic_scan
    import seg_pkg::*;
#(
    parameter int CNT_MAX = 49_999
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic [3:0] unit,
    input  logic [3:0] ten,
    input  logic [3:0] hun,
    input  logic [3:0] tho,
    input  logic [3:0] t_tho,
    input  logic [3:0] h_hun,
    input  logic [5:0] point,
    input  logic       sign,
    input  logic       seg_en,
    output logic [5:0] sel,
    output logic [7:0] seg,
    output logic       frame_done
);

    localparam int CW = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
    localparam logic [CW-1:0] CNT_TOP = CW'(CNT_MAX);
    localparam logic [2:0] IDX_LAST = 3'(NUM_DIGITS - 1);

    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic            tick;
    logic            load;
    logic            load_pend_q;
    logic [5:0][3:0] dig_q;
    logic [5:0]      point_q;
    logic            sign_q;
    logic [5:0]      sel_q;
    logic [7:0]      seg_q;
    logic            frame_done_q;

    logic [2:0]      msd_c;
    logic [2:0]      eff_c;
    logic [7:0]      code_c;

    assign tick = (cnt_q == CNT_TOP);

    // Shadow copy refreshes only at frame boundaries, so a frame is never torn.
    assign load = load_pend_q | (tick & (idx_q == IDX_LAST));

    always_comb begin
        cnt_d = tick ? '0 : cnt_q + 1'b1;
        idx_d = idx_q;
        if (tick) begin
            idx_d = (idx_q == IDX_LAST) ? 3'd0 : idx_q + 3'd1;
        end
    end

    // Highest nonzero digit, then widened to cover any lit decimal point.
    always_comb begin
        msd_c = 3'd0;
        eff_c = 3'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (dig_q[i] != 4'd0) begin
                msd_c = 3'(i);
            end
        end
        eff_c = msd_c;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (point_q[i] && 3'(i) > eff_c) begin
                eff_c = 3'(i);
            end
        end
    end

    always_comb begin
        code_c = SEG_BLANK;
        if (idx_q <= eff_c) begin
            code_c = bcd_to_seg(dig_q[idx_q]);
        end else if (sign_q && eff_c != IDX_LAST
                     && idx_q == eff_c + 3'd1) begin
            code_c = SEG_MINUS;
        end
        if (point_q[idx_q] && code_c != SEG_BLANK) begin
            code_c[7] = 1'b0;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            cnt_q        <= '0;
            idx_q        <= 3'd0;
            load_pend_q  <= 1'b1;
            dig_q        <= '0;
            point_q      <= '0;
            sign_q       <= 1'b0;
            sel_q        <= 6'h00;
            seg_q        <= SEG_BLANK;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            load_pend_q  <= 1'b0;
            frame_done_q <= tick & (idx_q == IDX_LAST);
            if (load) begin
                dig_q   <= {h_hun, t_tho, tho, hun, ten, unit};
                point_q <= point;
                sign_q  <= sign;
            end
            // Stay dark until the first shadow load has landed.
            if (load_pend_q || !seg_en) begin
                sel_q <= 6'h00;
                seg_q <= SEG_BLANK;
            end else begin
                sel_q <= 6'b000001 << idx_q;
                seg_q <= code_c;
            end
        end
    end

    assign sel        = sel_q;
    assign seg        = seg_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_dynamic_scan.sv
// Self-checking bench for seg_dynamic_scan with CNT_MAX=4.
// Compares every cycle against a frame-level display model.
module tb_seg_dynamic_scan;

    localparam int CNT_MAX = 4;
    localparam int DWELL   = CNT_MAX + 1;
    localparam int FRAME   = DWELL * 6;

    localparam logic [7:0] GLYPH [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF
    };

    logic            sys_clk;
    logic            sys_rst;
    logic [5:0][3:0] din;
    logic [5:0]      point;
    logic            sign;
    logic            seg_en;
    logic [5:0]      sel;
    logic [7:0]      seg;
    logic            frame_done;

    int n_assert;
    int n_fail;
    int k;

    logic [5:0][3:0] s_dig;
    logic [5:0]      s_pt;
    logic            s_sg;

    seg_dynamic_scan #(.CNT_MAX(CNT_MAX)) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .unit      (din[0]),
        .ten       (din[1]),
        .hun       (din[2]),
        .tho       (din[3]),
        .t_tho     (din[4]),
        .h_hun     (din[5]),
        .point     (point),
        .sign      (sign),
        .seg_en    (seg_en),
        .sel       (sel),
        .seg       (seg),
        .frame_done(frame_done)
    );

    initial begin
        sys_clk = 1'b0;
        forever #10 sys_clk = ~sys_clk;
    end

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s k=%0d observed=%h expected=%h",
                   tag, k, obs, exp);
        end
    endtask

    // Display model: the number occupies 'width' positions from the right;
    // the sign sits just left of it when there is room.
    function automatic logic [7:0] ref_seg(input logic [5:0][3:0] dg,
                                           input logic [5:0] pt,
                                           input logic sg, input int d);
        int width;
        logic [7:0] r;
        width = 1;
        for (int i = 0; i < 6; i++)
            if (dg[i] != 4'd0 || pt[i]) width = i + 1;
        if (d < width) r = GLYPH[dg[d]];
        else if (sg && d == width && width < 6) r = 8'hBF;
        else r = 8'hFF;
        if (pt[d] && r != 8'hFF) r[7] = 1'b0;
        return r;
    endfunction

    // One clock: capture snapshot at frame boundaries, then check outputs.
    task automatic step();
        logic [5:0][3:0] pd;
        logic [5:0]      pp;
        logic            ps;
        logic            en;
        logic [5:0]      e_sel;
        logic [7:0]      e_seg;
        int              d;
        pd = s_dig;
        pp = s_pt;
        ps = s_sg;
        en = seg_en;
        if (k + 1 == 1 || (k + 1) % FRAME == 0) begin
            s_dig = din;
            s_pt  = point;
            s_sg  = sign;
        end
        @(posedge sys_clk);
        k++;
        @(negedge sys_clk);
        if (k <= 1 || !en) begin
            e_sel = 6'h00;
            e_seg = 8'hFF;
        end else begin
            d     = ((k - 1) / DWELL) % 6;
            e_sel = 6'b000001 << d;
            e_seg = ref_seg(pd, pp, ps, d);
        end
        chk("sel", {2'b00, sel}, {2'b00, e_sel});
        chk("seg", seg, e_seg);
        chk("frame_done", {7'd0, frame_done}, {7'd0, k % FRAME == 0});
    endtask

    task automatic do_reset();
        sys_rst = 1'b1;
        #1;
        chk("rst_sel", {2'b00, sel}, 8'h00);
        chk("rst_seg", seg, 8'hFF);
        chk("rst_fd", {7'd0, frame_done}, 8'h00);
        @(negedge sys_clk);
        @(negedge sys_clk);
        sys_rst = 1'b0;
        k = 0;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        k        = 0;
        s_dig    = '0;
        s_pt     = '0;
        s_sg     = 1'b0;
        sys_rst  = 1'b0;
        din      = {4'd9, 4'd8, 4'd7, 4'd6, 4'd5, 4'd4};
        point    = 6'b000000;
        sign     = 1'b0;
        seg_en   = 1'b1;

        // Reset between edges, no clock needed.
        #5;
        do_reset();
        repeat (2 * FRAME + 2) step();

        // Mid-frame input change while digit 2 is showing.
        repeat (10) step();
        din = {4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd1};
        repeat (FRAME + 20) step();

        din  = {4'd0, 4'd0, 4'd0, 4'd0, 4'd4, 4'd2};
        sign = 1'b1;
        repeat (2 * FRAME) step();

        din   = '0;
        sign  = 1'b0;
        point = 6'b000100;
        repeat (2 * FRAME) step();

        // Full width: sign has no room.
        din   = {4'd9, 4'd0, 4'd3, 4'd0, 4'd0, 4'd7};
        sign  = 1'b1;
        point = 6'b100001;
        repeat (2 * FRAME) step();

        point = 6'b000000;
        sign  = 1'b0;
        repeat (7) step();
        seg_en = 1'b0;
        repeat (12) step();
        seg_en = 1'b1;
        repeat (FRAME) step();

        // Reset in the middle of a frame.
        repeat (13) step();
        do_reset();
        repeat (FRAME) step();

        repeat (600) begin
            if ($urandom_range(0, 9) == 0) begin
                for (int i = 0; i < 6; i++) begin
                    if ($urandom_range(0, 2) == 0) din[i] = 4'd0;
                    else if ($urandom_range(0, 9) == 0)
                        din[i] = 4'($urandom_range(10, 15));
                    else din[i] = 4'($urandom_range(0, 9));
                end
                point = ($urandom_range(0, 3) == 0) ?
                        6'($urandom) : 6'd0;
                sign  = 1'($urandom);
            end
            if ($urandom_range(0, 19) == 0) seg_en = ~seg_en;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
